// File: rtl/tqv_bus_pkg.sv
// Shared encodings, FSM state type and size-mask helper for the TinyQV bus initiator.
package tqv_bus_pkg;

   localparam logic [1:0] SIZE_B    = 2'b00;
   localparam logic [1:0] SIZE_H    = 2'b01;
   localparam logic [1:0] SIZE_W    = 2'b10;
   localparam logic [1:0] SIZE_IDLE = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StRead,
      StResp
   } state_e;

   // Zero the bytes above the transfer size.
   function automatic logic [31:0] size_mask(input logic [31:0] data, input logic [1:0] size);
      case (size)
         SIZE_B:  return {24'h0, data[7:0]};
         SIZE_H:  return {16'h0, data[15:0]};
         SIZE_W:  return data;
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/tqvp_bus_initiator.sv
// Single-outstanding initiator for the TinyQV peripheral bus.
// Define TQV_INIT_TIMEOUT_EN to compile in the read-wait counter and abort path.
module tqvp_bus_initiator
   import tqv_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [5:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [5:0]  address,
   output logic [31:0] data_in,
   output logic [1:0]  data_write_n,
   output logic [1:0]  data_read_n,
   input  logic [31:0] data_out,
   input  logic        data_ready,
   output logic        busy
);

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..255");
   end

   state_e      state_q, state_d;
   logic [1:0]  size_q, size_d;
   logic [5:0]  address_q, address_d;
   logic [31:0] data_in_q, data_in_d;
   logic [1:0]  write_n_q, write_n_d;
   logic [1:0]  read_n_q, read_n_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
`ifdef TQV_INIT_TIMEOUT_EN
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0]  cnt_q, cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      address_d   = address_q;
      data_in_d   = data_in_q;
      write_n_d   = write_n_q;
      read_n_d    = read_n_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef TQV_INIT_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (req_size == SIZE_IDLE) begin
                  // Illegal size: answer with an error, never touch the bus.
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = 32'h0;
                  rsp_err_d   = 1'b1;
               end else begin
                  size_d    = req_size;
                  address_d = req_addr;
                  if (req_write) begin
                     data_in_d = size_mask(req_wdata, req_size);
                     write_n_d = req_size;
                     state_d   = StWrite;
                  end else begin
                     read_n_d = req_size;
                     state_d  = StRead;
`ifdef TQV_INIT_TIMEOUT_EN
                     cnt_d    = 8'h0;
`endif
                  end
               end
            end
         end
         StWrite: begin
            write_n_d   = SIZE_IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b0;
            state_d     = StResp;
         end
         StRead: begin
            if (data_ready) begin
               read_n_d    = SIZE_IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = size_mask(data_out, size_q);
               rsp_err_d   = 1'b0;
               state_d     = StResp;
`ifdef TQV_INIT_TIMEOUT_EN
            end else if (cnt_q == TimeoutLast) begin
               read_n_d    = SIZE_IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b1;
               state_d     = StResp;
            end else begin
               cnt_d = cnt_q + 8'h1;
`endif
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         size_q      <= SIZE_B;
         address_q   <= 6'h0;
         data_in_q   <= 32'h0;
         write_n_q   <= SIZE_IDLE;
         read_n_q    <= SIZE_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
`ifdef TQV_INIT_TIMEOUT_EN
         cnt_q       <= 8'h0;
`endif
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         address_q   <= address_d;
         data_in_q   <= data_in_d;
         write_n_q   <= write_n_d;
         read_n_q    <= read_n_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef TQV_INIT_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign req_ready    = (state_q == StIdle);
   assign busy         = (state_q != StIdle);
   assign address      = address_q;
   assign data_in      = data_in_q;
   assign data_write_n = write_n_q;
   assign data_read_n  = read_n_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Directed scoreboard bench for tqvp_bus_initiator; timeout abort checked when
// TQV_INIT_TIMEOUT_EN is defined.
module tb_tqvp_bus_initiator;

`ifdef TQV_INIT_TIMEOUT_EN
   localparam int unsigned TO = 4;
`else
   localparam int unsigned TO = 255;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [1:0]  req_size;
   logic [5:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [5:0]  address;
   logic [31:0] data_in, data_out;
   logic [1:0]  data_write_n, data_read_n;
   logic        data_ready, busy;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   tqvp_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .address      (address),
      .data_in      (data_in),
      .data_write_n (data_write_n),
      .data_read_n  (data_read_n),
      .data_out     (data_out),
      .data_ready   (data_ready),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one command; returns in the first cycle after the accepting edge.
   task automatic issue(input logic w, input logic [1:0] sz, input logic [5:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rdata,
                        input logic exp_err, input bit push);
      req_valid = 1'b1;
      req_write = w;
      req_size  = sz;
      req_addr  = a;
      req_wdata = d;
      chk("req_ready_before_accept", {31'h0, req_ready}, 32'h1);
      step();
      req_valid = 1'b0;
      if (push) exp_q.push_back({exp_err, exp_rdata});
   endtask

   // Wait (bounded) for a response, score it, complete the handshake.
   task automatic take_rsp(input string tag);
      logic [32:0] e;
      int n = 0;
      while (!rsp_valid && n < 300) begin
         step();
         n++;
      end
      chk({tag, "_rsp_arrived"}, {31'h0, rsp_valid}, 32'h1);
      chk({tag, "_sb_pending"}, exp_q.size(), 32'h1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
         chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, e[32]});
      end
      rsp_ready = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_addr = 6'h0; req_wdata = 32'h0;
      rsp_ready = 1'b1; data_out = 32'h0; data_ready = 1'b0;
      #12;
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_write_n", {30'h0, data_write_n}, 32'h3);
      chk("rst_read_n", {30'h0, data_read_n}, 32'h3);
      chk("rst_address", {26'h0, address}, 32'h0);
      chk("rst_data_in", data_in, 32'h0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      step();

      // 32-bit write: one strobe cycle, response the cycle after.
      issue(1'b1, 2'b10, 6'h05, 32'hA5A5_1234, 32'h0, 1'b0, 1'b1);
      chk("wr32_write_n", {30'h0, data_write_n}, 32'h2);
      chk("wr32_address", {26'h0, address}, 32'h05);
      chk("wr32_data_in", data_in, 32'hA5A5_1234);
      chk("wr32_read_n", {30'h0, data_read_n}, 32'h3);
      chk("wr32_busy", {31'h0, busy}, 32'h1);
      chk("wr32_req_ready", {31'h0, req_ready}, 32'h0);
      chk("wr32_rsp_early", {31'h0, rsp_valid}, 32'h0);
      step();
      chk("wr32_write_n_release", {30'h0, data_write_n}, 32'h3);
      chk("wr32_rsp_t2", {31'h0, rsp_valid}, 32'h1);
      take_rsp("wr32");

      // Back-to-back byte write, upper bits of wdata must be masked.
      issue(1'b1, 2'b00, 6'h3F, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
      chk("wr8_write_n", {30'h0, data_write_n}, 32'h0);
      chk("wr8_data_in", data_in, 32'h0000_00EF);
      chk("wr8_address", {26'h0, address}, 32'h3F);
      step();
      take_rsp("wr8");

      // Byte read, data_ready three cycles after the strobe appears.
      data_out = 32'hFFFF_FF7E;
      issue(1'b0, 2'b00, 6'h10, 32'h0, 32'h0000_007E, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("rd8_read_n_held", {30'h0, data_read_n}, 32'h0);
         chk("rd8_write_n_idle", {30'h0, data_write_n}, 32'h3);
         chk("rd8_no_rsp", {31'h0, rsp_valid}, 32'h0);
         if (i == 3) data_ready = 1'b1;
         step();
      end
      data_ready = 1'b0;
      chk("rd8_address", {26'h0, address}, 32'h10);
      chk("rd8_read_n_release", {30'h0, data_read_n}, 32'h3);
      take_rsp("rd8");

      // Illegal size: immediate error, no strobes.
      issue(1'b1, 2'b11, 6'h22, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
      chk("ill_rsp_t1", {31'h0, rsp_valid}, 32'h1);
      chk("ill_write_n", {30'h0, data_write_n}, 32'h3);
      chk("ill_read_n", {30'h0, data_read_n}, 32'h3);
      take_rsp("ill");

      // Word read with data_ready on the fourth read edge (timeout edge with TO=4).
      data_out = 32'h1357_9BDF;
      issue(1'b0, 2'b10, 6'h01, 32'h0, 32'h1357_9BDF, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("rd32_read_n_held", {30'h0, data_read_n}, 32'h2);
         if (i == 3) data_ready = 1'b1;
         step();
      end
      data_ready = 1'b0;
      take_rsp("rd32_edge");

`ifdef TQV_INIT_TIMEOUT_EN
      // No responder: abort after four strobe cycles.
      issue(1'b0, 2'b01, 6'h02, 32'h0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("to_read_n_held", {30'h0, data_read_n}, 32'h1);
         step();
      end
      chk("to_read_n_release", {30'h0, data_read_n}, 32'h3);
      take_rsp("timeout");
`endif

      // Response stall: outputs stable and no accept while rsp_ready is low.
      rsp_ready = 1'b0;
      data_out = 32'h1234_ABCD;
      issue(1'b0, 2'b01, 6'h0C, 32'h0, 32'h0000_ABCD, 1'b0, 1'b1);
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
         chk("stall_rsp_rdata", rsp_rdata, 32'h0000_ABCD);
         chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
         step();
      end
      take_rsp("stall");
      chk("stall_idle_req_ready", {31'h0, req_ready}, 32'h1);
      chk("stall_idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);

      // Reset mid-read: strobe drops asynchronously and the read is dropped.
      issue(1'b0, 2'b10, 6'h07, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      chk("rstmid_read_n_before", {30'h0, data_read_n}, 32'h2);
      #2;
      reset = 1'b1;
      #1;
      chk("rstmid_read_n_async", {30'h0, data_read_n}, 32'h3);
      chk("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rstmid_busy", {31'h0, busy}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rstmid_no_rsp", {31'h0, rsp_valid}, 32'h0);
         chk("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
         step();
      end
      issue(1'b1, 2'b01, 6'h2A, 32'hCAFE_BEEF, 32'h0, 1'b0, 1'b1);
      chk("post_rst_write_n", {30'h0, data_write_n}, 32'h1);
      chk("post_rst_data_in", data_in, 32'h0000_BEEF);
      chk("post_rst_address", {26'h0, address}, 32'h2A);
      step();
      take_rsp("post_rst_wr");

      chk("sb_drained", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tqvp_bus_initiator.md
# tqvp_bus_initiator

Initiator for the TinyQV peripheral bus: accepts single read/write requests on a valid/ready command port and drives `address`/`data_write_n`/`data_read_n` toward a peripheral (e.g. the sprite engine's register RAM), collecting `data_out` on `data_ready`. It is the host-side counterpart of the peripheral register interface. It is used by the sprite animation sequencer and as a bus-functional master in system benches. Exactly one transaction is outstanding at a time.

## Interface
- `TIMEOUT_CYCLES`, default 255: read-wait cycles before abort (only with `TQV_INIT_TIMEOUT_EN`); legal range 1–255.
- `clk` in 1: project clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: command valid.
- `req_ready` out 1: command accepted when high with `req_valid` at a rising edge.
- `req_write` in 1: 1 = write, 0 = read.
- `req_size` in 2: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal.
- `req_addr` in 6: peripheral address.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: response valid; held until `rsp_ready`.
- `rsp_ready` in 1: response consumer ready.
- `rsp_rdata` out 32: read data, zero-extended per size; 0 for writes and errors.
- `rsp_err` out 1: 1 = illegal size or timeout.
- `address` out 6: to peripheral.
- `data_in` out 32: to peripheral (write data).
- `data_write_n` out 2: 11 = idle, else size code.
- `data_read_n` out 2: 11 = idle, else size code.
- `data_out` in 32: from peripheral.
- `data_ready` in 1: from peripheral, read data valid.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE: `req_ready`=1. On accept, latch addr, size, write flag, and masked wdata (bits above size zeroed).
  - Size 11: go to RESP with `rsp_err`=1; no bus activity.
  - Write: go to WRITE.
  - Read: go to READ and clear the wait counter.
- WRITE: drive `data_write_n`=size, `address`, `data_in` for exactly one cycle, then go to RESP with `rsp_err`=0 and `rsp_rdata`=0.
- READ: hold `data_read_n`=size and `address`. Each cycle the counter increments.
  - `data_ready`=1 at an edge: capture `data_out` masked to size (8-bit keeps [7:0], 16-bit keeps [15:0], upper bits 0), then go to RESP.
  - Timeout: counter reaches `TIMEOUT_CYCLES` with no `data_ready`: set `rsp_err`=1, `rsp_rdata`=0, go to RESP.
  - If `data_ready` arrives on the same edge as the timeout, `data_ready` wins.
- RESP: `rsp_valid`=1, bus idle (11/11). When `rsp_ready`=1 at an edge, go to IDLE. No new command is accepted in RESP; a back-to-back accept is possible on the first IDLE cycle.
- `data_write_n` and `data_read_n` are never both non-11 in the same cycle.
- Reset mid-transaction:
  - Bus strobes return to 11 immediately (asynchronous).
  - The transaction is dropped and no response is issued.

## Timing
- All bus and response outputs are registered; `req_ready` and `busy` decode directly from the state register.
- Reset values:
  - `req_ready`=1, `busy`=0.
  - `data_write_n`=`data_read_n`=11.
  - `address`=0, `data_in`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Accept at edge T:
  - Write: strobe in cycle T+1; `rsp_valid` from T+2.
  - Read: strobe from T+1. If `data_ready` is sampled at edge T+1+k, `rsp_valid` rises in cycle T+2+k and `data_read_n` is 11 in that same cycle.
  - Illegal size: `rsp_valid` from T+1.
- Minimum request-to-request spacing: 3 cycles for writes with `rsp_ready` tied high.

## Configuration
- `TQV_INIT_TIMEOUT_EN` defined: the wait counter and abort path are compiled in, as described in Operation.
- `TQV_INIT_TIMEOUT_EN` undefined:
  - No counter; READ waits for `data_ready` indefinitely.
  - `rsp_err` is asserted only for size 11.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `tqv_bus_pkg` contains:
  - size encodings (`SIZE_B`=00, `SIZE_H`=01, `SIZE_W`=10, `SIZE_IDLE`=11);
  - the state enum;
  - the size-mask function (shared by the write-data and read-data paths).
- Single module, no sub-modules; the wait counter is inline (8 bits).

## Test plan
- Write, addr 0x05, size 10, data 0xA5A5_1234 → one cycle with `data_write_n`=10, `address`=0x05, `data_in`=0xA5A5_1234 → `rsp_valid` at T+2 with `rsp_err`=0.
- Byte read, addr 0x10; responder returns `data_out`=0xFFFF_FF7E with `data_ready` 3 cycles after strobe → `data_read_n`=00 held 4 cycles → `rsp_rdata`=0x0000_007E, `rsp_err`=0.
- Size 11 request → no strobe at any point → `rsp_valid` at T+1 with `rsp_err`=1.
- With the macro and `TIMEOUT_CYCLES`=4, responder never sets `data_ready` → strobe released after 4 cycles → `rsp_err`=1, `rsp_rdata`=0. Repeat with `data_ready` on the timeout edge → `rsp_err`=0 and data captured.
- `rsp_ready` held low for 5 cycles → `rsp_valid` and `rsp_rdata` remain stable and `req_ready`=0 throughout; `rsp_ready` high → IDLE next cycle.
- `reset` asserted mid-read → `data_read_n`=11 asynchronously and no `rsp_valid`; after release `req_ready`=1 and a new write completes normally.
